lcd_pattern_gen: RTL

- Pixel source directly upstream of lcd_timing on the 800x480 RGB666 panel path.
- lcd_timing issues per-pixel requests (enable, x, y, frame start). This block returns RGB666 data with a fixed 2-cycle latency.
- The on-board user key, debounced, cycles through five test patterns. Pattern changes take effect only on frame boundaries.

---
 rtl/lcd_pkg.sv | 50 +++++
 rtl/key_debounce.sv | 56 +++++
 rtl/lcd_pattern_gen.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// Shared constants, pattern encodings and colour table for the LCD pattern generator.
package lcd_pkg;

    localparam int unsigned H_ACTIVE_DEF = 800;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned RGB_W        = 6;
    localparam int unsigned PAT_NUM      = 5;
    localparam int unsigned PAT_W        = 3;
    localparam int unsigned X_W          = 11;
    localparam int unsigned Y_W          = 10;
    localparam int unsigned CHECK_CELL   = 40;
    localparam int unsigned SCROLL_W     = 32;
    localparam int unsigned GREY_MUL     = 41;
    localparam int unsigned GREY_SHIFT   = 9;

    localparam logic [PAT_W-1:0] PAT_BARS    = 3'd0;
    localparam logic [PAT_W-1:0] PAT_GREY    = 3'd1;
    localparam logic [PAT_W-1:0] PAT_CHECKER = 3'd2;
    localparam logic [PAT_W-1:0] PAT_SOLID   = 3'd3;
    localparam logic [PAT_W-1:0] PAT_SCROLL  = 3'd4;

    typedef struct packed {
        logic [RGB_W-1:0] r;
        logic [RGB_W-1:0] g;
        logic [RGB_W-1:0] b;
    } rgb_t;

    localparam rgb_t C_WHITE   = '{r: 6'd63, g: 6'd63, b: 6'd63};
    localparam rgb_t C_YELLOW  = '{r: 6'd63, g: 6'd63, b: 6'd0};
    localparam rgb_t C_CYAN    = '{r: 6'd0,  g: 6'd63, b: 6'd63};
    localparam rgb_t C_GREEN   = '{r: 6'd0,  g: 6'd63, b: 6'd0};
    localparam rgb_t C_MAGENTA = '{r: 6'd63, g: 6'd0,  b: 6'd63};
    localparam rgb_t C_RED     = '{r: 6'd63, g: 6'd0,  b: 6'd0};
    localparam rgb_t C_BLUE    = '{r: 6'd0,  g: 6'd0,  b: 6'd63};
    localparam rgb_t C_BLACK   = '{r: 6'd0,  g: 6'd0,  b: 6'd0};

    function automatic rgb_t colour_lut(input logic [2:0] idx);
        case (idx)
            3'd0:    return C_WHITE;
            3'd1:    return C_YELLOW;
            3'd2:    return C_CYAN;
            3'd3:    return C_GREEN;
            3'd4:    return C_MAGENTA;
            3'd5:    return C_RED;
            3'd6:    return C_BLUE;
            default: return C_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// User key conditioner: two-flop synchronizer plus level debouncer, one-cycle press pulse out.
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 200000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_raw,
    output logic press
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             key_db_q, key_db_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Released level (1) is the reset state so no press is seen out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            key_db_q <= 1'b1;
            press_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            key_db_q <= key_db_d;
            press_q  <= press_d;
            cnt_q    <= cnt_d;
        end
    end

    // Count while the synced level disagrees; any agreement restarts the count.
    always_comb begin
        sync1_d  = key_raw;
        sync2_d  = sync1_q;
        key_db_d = key_db_q;
        press_d  = 1'b0;
        cnt_d    = '0;
        if (sync2_q != key_db_q) begin
            if (cnt_q == CNT_MAX) begin
                key_db_d = sync2_q;
                press_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign press = press_q;

endmodule

// File: rtl/lcd_pattern_gen.sv
// Test-pattern pixel source for lcd_timing, 2-cycle latency. Optional LCD_BORDER_EN forces
// a white one-pixel frame around the active area.
module lcd_pattern_gen
    import lcd_pkg::*;
#(
    parameter int unsigned H_ACTIVE        = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE        = V_ACTIVE_DEF,
    parameter int unsigned DEBOUNCE_CYCLES = 200000,
    parameter int unsigned BAR_SPEED       = 4
) (
    input  logic             lcd_clk,
    input  logic             rst_n,
    input  logic             uset_key,
    input  logic             pix_req,
    input  logic [X_W-1:0]   pix_x,
    input  logic [Y_W-1:0]   pix_y,
    input  logic             frame_start,
    output logic             pix_valid,
    output logic [RGB_W-1:0] pix_r,
    output logic [RGB_W-1:0] pix_g,
    output logic [RGB_W-1:0] pix_b,
    output logic [PAT_W-1:0] pattern_idx
);

    localparam int unsigned D_W   = X_W + 1;
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic key_press;

    logic [PAT_W-1:0] pending_q, pending_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [X_W-1:0]   offset_q, offset_d;
    logic [5:0]       frame_cnt_q, frame_cnt_d;
    logic [2:0]       solid_q, solid_d;

    logic             req1_q, req1_d;
    logic             inr1_q, inr1_d;
    logic [X_W-1:0]   x1_q, x1_d;
    logic [Y_W-1:0]   y1_q, y1_d;

    logic             valid_q, valid_d;
    rgb_t             rgb_q, rgb_d;

    logic [D_W-1:0]   offset_sum;
    logic [2:0]       bar_idx;
    logic [16:0]      grey_prod;
    logic [RGB_W-1:0] grey_lvl;
    logic [D_W-1:0]   scroll_diff;
    logic             chk_odd;
    rgb_t             colour;

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk    (lcd_clk),
        .rst_n  (rst_n),
        .key_raw(uset_key),
        .press  (key_press)
    );

    always_ff @(posedge lcd_clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            pattern_q   <= '0;
            offset_q    <= '0;
            frame_cnt_q <= '0;
            solid_q     <= '0;
            req1_q      <= 1'b0;
            inr1_q      <= 1'b0;
            x1_q        <= '0;
            y1_q        <= '0;
            valid_q     <= 1'b0;
            rgb_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            pattern_q   <= pattern_d;
            offset_q    <= offset_d;
            frame_cnt_q <= frame_cnt_d;
            solid_q     <= solid_d;
            req1_q      <= req1_d;
            inr1_q      <= inr1_d;
            x1_q        <= x1_d;
            y1_q        <= y1_d;
            valid_q     <= valid_d;
            rgb_q       <= rgb_d;
        end
    end

    // Key selection and per-frame state; frame_start latches the old pending value.
    always_comb begin
        pending_d   = pending_q;
        pattern_d   = pattern_q;
        offset_d    = offset_q;
        frame_cnt_d = frame_cnt_q;
        solid_d     = solid_q;
        offset_sum  = {1'b0, offset_q} + D_W'(BAR_SPEED);
        if (key_press) begin
            pending_d = (pending_q == PAT_W'(PAT_NUM - 1)) ? '0 : pending_q + 3'd1;
        end
        if (frame_start) begin
            pattern_d   = pending_q;
            offset_d    = (offset_sum >= D_W'(H_ACTIVE)) ? X_W'(offset_sum - D_W'(H_ACTIVE))
                                                         : X_W'(offset_sum);
            frame_cnt_d = frame_cnt_q + 6'd1;
            if (frame_cnt_q == 6'd63) begin
                solid_d = solid_q + 3'd1;
            end
        end
    end

    // Stage 1: capture request and range check.
    always_comb begin
        req1_d = pix_req;
        x1_d   = pix_x;
        y1_d   = pix_y;
        inr1_d = (pix_x < X_W'(H_ACTIVE)) && (pix_y < Y_W'(V_ACTIVE));
    end

    // Stage 2: pattern colour from the registered coordinates.
    always_comb begin
        bar_idx = '0;
        for (int unsigned i = 1; i < 8; i++) begin
            if (x1_q >= X_W'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
        grey_prod   = 17'(x1_q) * 17'(GREY_MUL);
        grey_lvl    = RGB_W'(grey_prod >> GREY_SHIFT);
        scroll_diff = (x1_q >= offset_q) ? ({1'b0, x1_q} - {1'b0, offset_q})
                                         : ({1'b0, x1_q} + D_W'(H_ACTIVE) - {1'b0, offset_q});
        chk_odd     = (((x1_q / X_W'(CHECK_CELL)) + X_W'(y1_q / Y_W'(CHECK_CELL))) % X_W'(2)) != '0;

        case (pattern_q)
            PAT_BARS:    colour = colour_lut(bar_idx);
            PAT_GREY:    colour = '{r: grey_lvl, g: grey_lvl, b: grey_lvl};
            PAT_CHECKER: colour = chk_odd ? C_BLACK : C_WHITE;
            PAT_SOLID:   colour = colour_lut(solid_q);
            PAT_SCROLL:  colour = (scroll_diff < D_W'(SCROLL_W)) ? C_WHITE : C_BLUE;
            default:     colour = C_BLACK;
        endcase

`ifdef LCD_BORDER_EN
        if ((x1_q == '0) || (x1_q == X_W'(H_ACTIVE - 1)) ||
            (y1_q == '0) || (y1_q == Y_W'(V_ACTIVE - 1))) begin
            colour = C_WHITE;
        end
`endif

        valid_d = req1_q;
        rgb_d   = (req1_q && inr1_q) ? colour : '0;
    end

    assign pix_valid   = valid_q;
    assign pix_r       = rgb_q.r;
    assign pix_g       = rgb_q.g;
    assign pix_b       = rgb_q.b;
    assign pattern_idx = pattern_q;

endmodule
